// File: rtl/fp_pkg.sv
//------------------------------------------------------------------------------
// Module   : fp_pkg
// Purpose  : Shared constants and FSM state encoding for the sequential
//            single-precision adder/subtractor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam int          MANT_W  = 23;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_classify.sv
//------------------------------------------------------------------------------
// Module   : fp_classify
// Purpose  : Combinational unpack of one IEEE-754 single into fields and flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       op_i,
    output logic              sign_o,
    output logic [7:0]        exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              is_nan_o,
    output logic              is_inf_o,
    output logic              is_zero_o
);

    assign sign_o    = op_i[31];
    assign exp_o     = op_i[30:23];
    assign mant_o    = op_i[MANT_W-1:0];

    // Denormals have exponent 0 and are treated as zero.
    assign is_nan_o  = (exp_o == EXP_MAX) && (mant_o != '0);
    assign is_inf_o  = (exp_o == EXP_MAX) && (mant_o == '0);
    assign is_zero_o = (exp_o == 8'd0);

endmodule : fp_classify

`default_nettype wire

// File: rtl/fp_addsub_seq.sv
//------------------------------------------------------------------------------
// Module   : fp_addsub_seq
// Purpose  : Multi-cycle single-precision add/subtract, truncating, with
//            valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_addsub_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow
);

    state_t      state_q,  state_d;
    logic        sign_q,   sign_d;
    logic        sub_q,    sub_d;
    logic [7:0]  exp_q,    exp_d;
    logic [7:0]  diff_q,   diff_d;
    logic [23:0] big_q,    big_d;
    logic [23:0] small_q,  small_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q,    ovf_d;

    logic              a_sign, b_sign;
    logic [7:0]        a_exp,  b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic              a_nan,  a_inf, a_zero;
    logic              b_nan,  b_inf, b_zero;

    fp_classify u_class_a (
        .op_i      (a),
        .sign_o    (a_sign),
        .exp_o     (a_exp),
        .mant_o    (a_mant),
        .is_nan_o  (a_nan),
        .is_inf_o  (a_inf),
        .is_zero_o (a_zero)
    );

    fp_classify u_class_b (
        .op_i      (b),
        .sign_o    (b_sign),
        .exp_o     (b_exp),
        .mant_o    (b_mant),
        .is_nan_o  (b_nan),
        .is_inf_o  (b_inf),
        .is_zero_o (b_zero)
    );

    logic        w_eff_b_sign;
    logic        w_a_ge_b;
    logic [24:0] w_sum;
    logic [23:0] w_shl;

    assign w_eff_b_sign = b_sign ^ op;
    assign w_a_ge_b     = {a_exp, a_mant} >= {b_exp, b_mant};
    assign w_sum        = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                : ({1'b0, big_q} + {1'b0, small_q});
    assign w_shl        = {big_q[22:0], 1'b0};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= 8'd0;
            diff_q   <= 8'd0;
            big_q    <= 24'd0;
            small_q  <= 24'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            diff_q   <= diff_d;
            big_q    <= big_d;
            small_q  <= small_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        diff_d   = diff_q;
        big_d    = big_q;
        small_d  = small_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ovf_d   = 1'b0;
                    state_d = DONE;
                    if (a_nan) begin
                        result_d = a;
                    end else if (b_nan) begin
                        result_d = b;
                    end else if (a_inf && b_inf && (a_sign != w_eff_b_sign)) begin
                        result_d = QNAN;
                    end else if (a_inf) begin
                        result_d = a;
                    end else if (b_inf) begin
                        result_d = {w_eff_b_sign, b[30:0]};
                    end else if (a_zero && b_zero) begin
                        result_d = {a_sign & w_eff_b_sign, 31'd0};
                    end else if (a_zero) begin
                        result_d = {w_eff_b_sign, b[30:0]};
                    end else if (b_zero) begin
                        result_d = a;
                    end else begin
                        sub_d = a_sign ^ w_eff_b_sign;
                        if (w_a_ge_b) begin
                            sign_d  = a_sign;
                            exp_d   = a_exp;
                            big_d   = {1'b1, a_mant};
                            small_d = {1'b1, b_mant};
                            diff_d  = a_exp - b_exp;
                        end else begin
                            sign_d  = w_eff_b_sign;
                            exp_d   = b_exp;
                            big_d   = {1'b1, b_mant};
                            small_d = {1'b1, a_mant};
                            diff_d  = b_exp - a_exp;
                        end
                        state_d = (diff_d == 8'd0) ? ADD : ALIGN;
                    end
                end
            end

            ALIGN: begin
                // Anything 25 or more places down truncates to nothing.
                if (diff_q >= 8'd25) begin
                    small_d = 24'd0;
                    diff_d  = 8'd0;
                    state_d = ADD;
                end else begin
                    small_d = small_q >> 1;
                    diff_d  = diff_q - 8'd1;
                    if (diff_q == 8'd1) begin
                        state_d = ADD;
                    end
                end
            end

            ADD: begin
                if (w_sum[24]) begin
                    state_d = DONE;
                    if (exp_q == (EXP_MAX - 8'd1)) begin
                        result_d = {sign_q, EXP_MAX, 23'd0};
                        ovf_d    = 1'b1;
                    end else begin
                        exp_d    = exp_q + 8'd1;
                        result_d = {sign_q, exp_q + 8'd1, w_sum[23:1]};
                    end
                end else if (w_sum[23]) begin
                    state_d  = DONE;
                    result_d = {sign_q, exp_q, w_sum[22:0]};
                end else begin
                    big_d   = w_sum[23:0];
                    state_d = NORM;
                end
            end

            NORM: begin
                // Cancellation to zero or exponent underflow both flush to +0.
                if ((big_q == 24'd0) || (exp_q == 8'd1)) begin
                    result_d = 32'd0;
                    state_d  = DONE;
                end else begin
                    big_d = w_shl;
                    exp_d = exp_q - 8'd1;
                    if (w_shl[23]) begin
                        result_d = {sign_q, exp_q - 8'd1, w_shl[22:0]};
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : fp_addsub_seq

`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_fp_addsub_seq
// Purpose  : Directed self-checking bench for fp_addsub_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;
    wire         in_ready;
    wire         out_valid;
    wire  [31:0] result;
    wire         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    // Present one operation, then wait (bounded) for out_valid; lat counts
    // rising edges from the capture edge to the first cycle out_valid is seen.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic top, output int lat, output bit timed_out);
        @(negedge clk);
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !out_valid;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_add;
        int lat; bit to;
        // 32.4 + 10.3: align by 2, no carry, no normalise -> latency 4.
        issue(32'h42019999, 32'h4124CCCC, 1'b0, lat, to);
        checks++; if (to || result !== 32'h422ACCCC) begin errors++; $display("FAIL add_32p4 got=%h want=422ACCCC", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_32p4_ovf got=%b want=0", overflow); end
        checks++; if (lat != 4) begin errors++; $display("FAIL add_32p4_latency got=%0d want=4", lat); end
        consume();
        // 1.0 + 2.0 with b the larger operand.
        issue(32'h3F800000, 32'h40000000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h40400000) begin errors++; $display("FAIL add_swap got=%h want=40400000", result); end
        consume();
    endtask

    task automatic test_sub;
        int lat; bit to;
        // Exact difference of the two operands: 0x3BF5C3 normalised by 2 -> 0x416FD70C.
        issue(32'h4243B852, 32'h4207C28F, 1'b1, lat, to);
        checks++; if (to || result !== 32'h416FD70C) begin errors++; $display("FAIL sub_48p93 got=%h want=416FD70C", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_48p93_ovf got=%b want=0", overflow); end
        checks++; if (lat != 4) begin errors++; $display("FAIL sub_48p93_latency got=%0d want=4", lat); end
        consume();
        // 1.0 - 2.0 = -1.0
        issue(32'h3F800000, 32'h40000000, 1'b1, lat, to);
        checks++; if (to || result !== 32'hBF800000) begin errors++; $display("FAIL sub_negative got=%h want=BF800000", result); end
        consume();
    endtask

    task automatic test_overflow;
        int lat; bit to;
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat, to);
        checks++; if (to || result !== 32'h7F800000) begin errors++; $display("FAIL ovf_result got=%h want=7F800000", result); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        checks++; if (lat != 2) begin errors++; $display("FAIL ovf_latency got=%0d want=2", lat); end
        consume();
    endtask

    task automatic test_specials;
        int lat; bit to;
        issue(32'h7F800000, 32'h7F800000, 1'b1, lat, to);
        checks++; if (to || result !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf got=%h want=7FC00000", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL inf_minus_inf_ovf got=%b want=0", overflow); end
        consume();
        issue(32'h7F800001, 32'h3F800000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h7F800001) begin errors++; $display("FAIL nan_a got=%h want=7F800001", result); end
        checks++; if (lat != 1) begin errors++; $display("FAIL nan_a_latency got=%0d want=1", lat); end
        consume();
        issue(32'h3F800000, 32'h7FC00123, 1'b1, lat, to);
        checks++; if (to || result !== 32'h7FC00123) begin errors++; $display("FAIL nan_b got=%h want=7FC00123", result); end
        consume();
        issue(32'h3F800000, 32'h7F800000, 1'b1, lat, to);
        checks++; if (to || result !== 32'hFF800000) begin errors++; $display("FAIL sub_inf_b got=%h want=FF800000", result); end
        consume();
        issue(32'h00000000, 32'h3F800000, 1'b1, lat, to);
        checks++; if (to || result !== 32'hBF800000) begin errors++; $display("FAIL zero_a got=%h want=BF800000", result); end
        consume();
        issue(32'h40000000, 32'h00000000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h40000000) begin errors++; $display("FAIL zero_b got=%h want=40000000", result); end
        consume();
        issue(32'h80000000, 32'h00000000, 1'b1, lat, to);
        checks++; if (to || result !== 32'h80000000) begin errors++; $display("FAIL both_zero got=%h want=80000000", result); end
        consume();
    endtask

    task automatic test_cancel;
        int lat; bit to;
        issue(32'h3F9D70A3, 32'h3F9D70A3, 1'b1, lat, to);
        checks++; if (to || result !== 32'h00000000) begin errors++; $display("FAIL cancel got=%h want=00000000", result); end
        checks++; if (lat != 3) begin errors++; $display("FAIL cancel_latency got=%0d want=3", lat); end
        consume();
    endtask

    task automatic test_align_boundary;
        int lat; bit to;
        // Difference 25: small operand zeroed in a single ALIGN cycle.
        issue(32'h4C000000, 32'h3F800000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h4C000000) begin errors++; $display("FAIL align25 got=%h want=4C000000", result); end
        checks++; if (lat != 3) begin errors++; $display("FAIL align25_latency got=%0d want=3", lat); end
        consume();
        // Difference 24: shifted one bit at a time until it truncates away.
        issue(32'h4B800000, 32'h3F800000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h4B800000) begin errors++; $display("FAIL align24 got=%h want=4B800000", result); end
        checks++; if (lat != 26) begin errors++; $display("FAIL align24_latency got=%0d want=26", lat); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat; bit to;
        issue(32'h42019999, 32'h4124CCCC, 1'b0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got=no out_valid want=out_valid"); end
        // Offer a new operation while busy; it must be ignored.
        a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h422ACCCC || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got ov=%b res=%h ir=%b want 1/422ACCCC/0", i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        repeat (3) @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_ghost got ov=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid_op;
        int lat; bit to; bit seen;
        @(negedge clk);
        a = 32'h42019999; b = 32'h4124CCCC; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
            errors++; $display("FAIL mid_reset got ov=%b ir=%b res=%h want 0/1/00000000", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_reset_ghost got out_valid=1 want=0"); end
        issue(32'h42019999, 32'h4124CCCC, 1'b0, lat, to);
        checks++; if (to || result !== 32'h422ACCCC) begin errors++; $display("FAIL mid_reset_rerun got=%h want=422ACCCC", result); end
        consume();
    endtask

    task automatic test_back_to_back;
        int lat; bit to;
        issue(32'h3F800000, 32'h3F800000, 1'b0, lat, to);
        checks++; if (to || result !== 32'h40000000) begin errors++; $display("FAIL b2b_first got=%h want=40000000", result); end
        consume();
        issue(32'h40400000, 32'h3F800000, 1'b1, lat, to);
        checks++; if (to || result !== 32'h40000000) begin errors++; $display("FAIL b2b_second got=%h want=40000000", result); end
        checks++; if (lat != 3) begin errors++; $display("FAIL b2b_second_latency got=%0d want=3", lat); end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_specials();
        test_cancel();
        test_align_boundary();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_addsub_seq

`default_nettype wire
